// File: rtl/vga_timing_controller.sv
// VGA raster timing generator: pixel-rate clock enable, h/v counters and
// registered sync/visible flags that update on the same edge as the counts.
module vga_timing_controller #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned H_VIS_END   = 783,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 514
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_en,
  output logic       frame_tick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSyncW    = 10'(H_SYNC);
  localparam logic [9:0] VSyncW    = 10'(V_SYNC);
  localparam logic [9:0] HVisStart = 10'(H_VIS_START);
  localparam logic [9:0] HVisEnd   = 10'(H_VIS_END);
  localparam logic [9:0] VVisStart = 10'(V_VIS_START);
  localparam logic [9:0] VVisEnd   = 10'(V_VIS_END);

  logic [DivW-1:0] div_cnt, div_d;
  logic [9:0]      hcount_d, vcount_d;
  logic            hsync_d, vsync_d, bright_d, frame_tick_d;

  // Gated by reset so a CLK_DIV=1 instance still reads 0 while held in reset.
  assign pix_en = !reset && (div_cnt == DivLast);

  always_comb begin
    div_d    = (div_cnt == DivLast) ? '0 : div_cnt + 1'b1;
    hcount_d = hCount;
    vcount_d = vCount;
    if (pix_en) begin
      if (hCount == HLast) begin
        hcount_d = '0;
        vcount_d = (vCount == VLast) ? '0 : vCount + 10'd1;
      end else begin
        hcount_d = hCount + 10'd1;
      end
    end
  end

  // Derived flags come from next-state counts so they align with the counters.
  always_comb begin
    hsync_d      = !(hcount_d < HSyncW);
    vsync_d      = !(vcount_d < VSyncW);
    bright_d     = (hcount_d >= HVisStart) && (hcount_d <= HVisEnd) &&
                   (vcount_d >= VVisStart) && (vcount_d <= VVisEnd);
    frame_tick_d = pix_en && (hCount == HLast) && (vCount == VLast);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      bright     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= div_d;
      hCount     <= hcount_d;
      vCount     <= vcount_d;
      hSync      <= hsync_d;
      vSync      <= vsync_d;
      bright     <= bright_d;
      frame_tick <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: three geometries driven by one clock and reset,
// checked every cycle against an arithmetic raster model through per-DUT queues.
module tb_vga_timing_controller;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       pe;
    logic       ft;
  } obs_t;

  // Small geometry A and a CLK_DIV=1 geometry B keep full frames short.
  localparam int unsigned AD = 3, AHT = 20, AHS = 3, AHVS = 5, AHVE = 16;
  localparam int unsigned AVT = 12, AVS = 2, AVVS = 3, AVVE = 9;
  localparam int unsigned BD = 1, BHT = 10, BHS = 2, BHVS = 2, BHVE = 7;
  localparam int unsigned BVT = 6, BVS = 1, BVVS = 1, BVVE = 4;

  logic clk;
  logic reset = 1'b0;

  logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
  logic a_hs, a_vs, a_br, a_pe, a_ft;
  logic b_hs, b_vs, b_br, b_pe, b_ft;
  logic c_hs, c_vs, c_br, c_pe, c_ft;

  vga_timing_controller #(
    .CLK_DIV(AD), .H_TOTAL(AHT), .H_SYNC(AHS), .H_VIS_START(AHVS), .H_VIS_END(AHVE),
    .V_TOTAL(AVT), .V_SYNC(AVS), .V_VIS_START(AVVS), .V_VIS_END(AVVE)
  ) u_dut_a (
    .clk(clk), .reset(reset), .hCount(a_h), .vCount(a_v), .hSync(a_hs), .vSync(a_vs),
    .bright(a_br), .pix_en(a_pe), .frame_tick(a_ft)
  );

  vga_timing_controller #(
    .CLK_DIV(BD), .H_TOTAL(BHT), .H_SYNC(BHS), .H_VIS_START(BHVS), .H_VIS_END(BHVE),
    .V_TOTAL(BVT), .V_SYNC(BVS), .V_VIS_START(BVVS), .V_VIS_END(BVVE)
  ) u_dut_b (
    .clk(clk), .reset(reset), .hCount(b_h), .vCount(b_v), .hSync(b_hs), .vSync(b_vs),
    .bright(b_br), .pix_en(b_pe), .frame_tick(b_ft)
  );

  vga_timing_controller u_dut_c (
    .clk(clk), .reset(reset), .hCount(c_h), .vCount(c_v), .hSync(c_hs), .vSync(c_vs),
    .bright(c_br), .pix_en(c_pe), .frame_tick(c_ft)
  );

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {a_h, a_v, a_hs, a_vs, a_br, a_pe, a_ft};
  assign obs_b = {b_h, b_v, b_hs, b_vs, b_br, b_pe, b_ft};
  assign obs_c = {c_h, c_v, c_hs, c_vs, c_br, c_pe, c_ft};

  obs_t q_a[$], q_b[$], q_c[$];
  int unsigned t;
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // t = clock edges since reset release; the raster position follows by division.
  function automatic obs_t model(input int unsigned t_in, input bit rst,
                                 input int unsigned d, ht, hs, hvs, hve, vt, vs, vvs, vve);
    obs_t o;
    int unsigned tt, h, v;
    tt   = rst ? 0 : t_in;
    h    = (tt / d) % ht;
    v    = (tt / (d * ht)) % vt;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hs = !(h < hs);
    o.vs = !(v < vs);
    o.br = (h >= hvs) && (h <= hve) && (v >= vvs) && (v <= vve);
    o.pe = !rst && (tt % d == d - 1);
    o.ft = (tt != 0) && (tt % (d * ht * vt) == 0);
    return o;
  endfunction

  task automatic push_all();
    q_a.push_back(model(t, reset, AD, AHT, AHS, AHVS, AHVE, AVT, AVS, AVVS, AVVE));
    q_b.push_back(model(t, reset, BD, BHT, BHS, BHVS, BHVE, BVT, BVS, BVVS, BVVE));
    q_c.push_back(model(t, reset, 4, 800, 96, 144, 783, 525, 2, 35, 514));
  endtask

  task automatic compare(input string name, input obs_t got, input obs_t exp, input bit have);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s @%0t: sample with no expected entry queued", name, $time);
    end else if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t t=%0d: got h=%0d v=%0d hs=%b vs=%b br=%b pe=%b ft=%b, expected h=%0d v=%0d hs=%b vs=%b br=%b pe=%b ft=%b",
               name, $time, t, got.h, got.v, got.hs, got.vs, got.br, got.pe, got.ft,
               exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.pe, exp.ft);
    end
  endtask

  task automatic sample();
    obs_t e;
    bit have;
    have = (q_a.size() != 0); e = have ? q_a.pop_front() : '0; compare("dut_a", obs_a, e, have);
    have = (q_b.size() != 0); e = have ? q_b.pop_front() : '0; compare("dut_b", obs_b, e, have);
    have = (q_c.size() != 0); e = have ? q_c.pop_front() : '0; compare("dut_c", obs_c, e, have);
  endtask

  // Monitors: once per clock after the edge, and right after any reset assertion.
  initial forever begin
    @(posedge clk);
    #3;
    sample();
  end

  initial forever begin
    @(posedge reset);
    #1;
    sample();
  end

  task automatic assert_reset();
    reset = 1'b1;
    push_all();
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) t = 0;
    else t++;
    #2;
    push_all();
  endtask

  initial begin
    int hold;
    t    = 0;
    hold = 0;
    #1;
    assert_reset();
    repeat (5) step();
    @(negedge clk);
    reset = 1'b0;
    // Long clean run: several frames of A and B, two full default lines of C.
    repeat (7000) step();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (hold > 0) begin
        hold--;
        if (hold == 0) reset = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 3));
        assert_reset();
        hold = $urandom_range(1, 3);
      end
      step();
    end
    #2;
    checks++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0",
               q_a.size() + q_b.size() + q_c.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
